// File: rtl/pdm_serializer_if.sv
// pdm_serializer_if: playback controller <-> serializer link
//   master (controller): drives enable, sample_in; observes audio_pwm, audio_sd, done, busy
//   slave (serializer):  the reverse
interface pdm_serializer_if #(parameter int WORD_BITS = 16);
  logic                 enable;
  logic [WORD_BITS-1:0] sample_in;
  logic                 audio_pwm;
  logic                 audio_sd;
  logic                 done;
  logic                 busy;
  modport master(output enable, sample_in, input audio_pwm, audio_sd, done, busy);
  modport slave(input enable, sample_in, output audio_pwm, audio_sd, done, busy);
endinterface

// File: rtl/pdm_serializer.sv
// pdm_serializer: shifts memory words out MSB first, one bit per CLK_DIV clocks
//   clock_i, reset_i (async, active high)
//   bus.enable, bus.sample_in in; bus.audio_pwm, bus.audio_sd, bus.done, bus.busy out
module pdm_serializer #(
  parameter int CLK_DIV   = 100,
  parameter int WORD_BITS = 16
) (
  input logic              clock_i,
  input logic              reset_i,
  pdm_serializer_if.slave  bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WORD_BITS);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e               state_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [DW-1:0]        div_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 done_q;
  logic                 tick, last, load;
  assign tick = div_q == DW'(CLK_DIV - 1);
  assign last = bit_cnt_q == BW'(WORD_BITS - 1);
  // a new word enters from IDLE or back-to-back at the word boundary
  assign load = bus.enable && (state_q == IDLE || (tick && last));
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= load;
      if (load) begin
        state_q   <= SHIFT;
        shift_q   <= bus.sample_in;
        div_q     <= '0;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick && last) begin
          // clearing the shifter keeps audio_pwm low while idle
          state_q   <= IDLE;
          shift_q   <= '0;
          bit_cnt_q <= '0;
        end else if (tick) begin
          shift_q   <= {shift_q[WORD_BITS-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  assign bus.audio_pwm = shift_q[WORD_BITS-1];
  assign bus.audio_sd  = state_q == SHIFT;
  assign bus.busy      = state_q == SHIFT;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_pdm_serializer.sv
// tb_pdm_serializer: random and directed checks of pdm_serializer (CLK_DIV 4 and 1) against a word/time model
module tb_pdm_serializer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [W-1:0] smp = '0;
  always #5 clk = ~clk;
  pdm_serializer_if #(.WORD_BITS(W)) if4();
  pdm_serializer_if #(.WORD_BITS(W)) if1();
  assign if4.enable = en;
  assign if4.sample_in = smp;
  assign if1.enable = en;
  assign if1.sample_in = smp;
  pdm_serializer #(.CLK_DIV(4), .WORD_BITS(W)) u4 (.clock_i(clk), .reset_i(rst), .bus(if4));
  pdm_serializer #(.CLK_DIV(1), .WORD_BITS(W)) u1 (.clock_i(clk), .reset_i(rst), .bus(if1));
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  int D[2] = '{4, 1};
  bit act[2];
  logic [W-1:0] word[2];
  int t[2];
  int loads[2] = '{0, 0};
  bit xdone[2];
  // model: a word occupies W*D cycles after its load; bit index follows from elapsed time
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        act[k] = 0;
        t[k] = 0;
        xdone[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        xdone[k] = 0;
        if (!act[k] || t[k] == W * D[k] - 1) begin
          if (en) begin
            act[k] = 1;
            word[k] = smp;
            t[k] = 0;
            xdone[k] = 1;
            loads[k]++;
          end else begin
            act[k] = 0;
            t[k] = 0;
          end
        end else t[k]++;
      end
    end
  function automatic logic xpwm(int k);
    return act[k] ? word[k][W - 1 - t[k] / D[k]] : 1'b0;
  endfunction
  int cyc = 0;
  int ndone[2] = '{0, 0};
  int last_d[2] = '{-1, -1};
  bit gap_on = 0;
  always @(posedge clk) begin
    logic [3:0] o[2];
    #1;
    cyc++;
    o[0] = {if4.audio_pwm, if4.audio_sd, if4.busy, if4.done};
    o[1] = {if1.audio_pwm, if1.audio_sd, if1.busy, if1.done};
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pwm%0d", k), o[k][3], xpwm(k));
      check($sformatf("sd%0d", k), o[k][2], act[k]);
      check($sformatf("busy%0d", k), o[k][1], act[k]);
      check($sformatf("done%0d", k), o[k][0], xdone[k]);
      if (!gap_on) last_d[k] = -1;
      if (o[k][0]) begin
        ndone[k]++;
        if (gap_on && last_d[k] >= 0) check($sformatf("gap%0d", k), cyc - last_d[k], W * D[k]);
        last_d[k] = gap_on ? cyc : -1;
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  logic [W-1:0] ws[3] = '{16'h8001, 16'h7FFE, 16'h0000};
  initial begin
    int i, nd, b;
    logic p;
    tick(2);
    rst = 1'b0;
    tick(2);
    // single word
    smp = 16'hA5C3;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(70);
    check("sd_idle", if4.audio_sd, 1'b0);
    // streaming, next word presented on each done
    smp = ws[0];
    en = 1'b1;
    gap_on = 1;
    i = 1;
    for (int c = 0; c < 300 && i < 4; c++) begin
      @(negedge clk);
      if (if4.done) begin
        if (i < 3) smp = ws[i];
        else en = 1'b0;
        i++;
      end
    end
    check("nwords", i, 4);
    en = 1'b0;
    gap_on = 0;
    tick(70);
    // enable dropped mid-word
    b = ndone[0];
    smp = 16'hFFFF;
    en = 1'b1;
    tick(21);
    en = 1'b0;
    tick(70);
    check("dis_done", ndone[0] - b, 1);
    check("dis_idle", if4.busy, 1'b0);
    // minimum divider: alternating bits every clock
    smp = 16'h5555;
    en = 1'b1;
    gap_on = 1;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #2;
      if (c > 0) check("tog1", if1.audio_pwm, !p);
      p = if1.audio_pwm;
    end
    @(negedge clk);
    en = 1'b0;
    gap_on = 0;
    tick(80);
    // boundary sampling: value on the boundary edge wins
    smp = 16'h0000;
    en = 1'b1;
    nd = 0;
    for (int c = 0; c < 200 && nd < 2; c++) begin
      @(negedge clk);
      if (if4.done) nd++;
    end
    check("bnd_wait", nd, 2);
    smp = 16'hFFFF;
    en = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      check("bnd_word", if4.audio_pwm, 1'b0);
    end
    tick(10);
    // reset mid-word
    smp = 16'hFFFF;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(10);
    rst = 1'b1;
    #1;
    check("rst_pwm", if4.audio_pwm, 1'b0);
    check("rst_sd", if4.audio_sd, 1'b0);
    check("rst_busy", if4.busy, 1'b0);
    check("rst_done", if4.done, 1'b0);
    tick(2);
    rst = 1'b0;
    b = ndone[0];
    tick(80);
    check("rst_nodone", ndone[0] - b, 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      smp = W'($urandom);
      if ($urandom_range(0, 99) < 3) en = ~en;
    end
    en = 1'b0;
    tick(70);
    check("ndone4", ndone[0], loads[0]);
    check("ndone1", ndone[1], loads[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
